// File: rtl/uart_byte_link.sv
// rtl/uart_byte_link.sv - byte-level UART transceiver, 8N1 LSB first, armed receive delivery.
// Define UART_BYTE_LINK_PARITY_EN to add an even-parity bit to both directions.
module uart_byte_link #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_uart_rx,
  output logic       out_uart_tx,
  input  logic       rx_trig,
  output logic       rx_done,
  output logic [7:0] data_rx,
  input  logic       tx_trig,
  input  logic [7:0] data_tx,
  output logic       tx_done,
  output logic       out_rx_overrun,
  output logic       out_rx_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_BYTE_LINK_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  // ---------------- receive path ----------------
  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic            rx_good, rx_bad;
  logic [7:0]      hold_data;
  logic            hold_valid, armed, deliver;
`ifdef UART_BYTE_LINK_PARITY_EN
  logic            rx_par, rx_par_n;
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
`ifdef UART_BYTE_LINK_PARITY_EN
    rx_par_n   = rx_par;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        // a start bit that is high again at mid-bit is treated as line noise
        if (rx_cnt == HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
`ifdef UART_BYTE_LINK_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
`ifdef UART_BYTE_LINK_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_par_n   = rx_s2;
          rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
`ifdef UART_BYTE_LINK_PARITY_EN
          rx_good = rx_s2 && (rx_par == ^rx_shift);
`else
          rx_good = rx_s2;
`endif
          rx_bad  = !rx_good;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // rx_trig counts as armed in its own cycle so delivery lands the cycle after
  assign deliver = hold_valid && (armed || rx_trig);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_s1          <= 1'b1;
      rx_s2          <= 1'b1;
      rx_prev        <= 1'b1;
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_shift       <= '0;
`ifdef UART_BYTE_LINK_PARITY_EN
      rx_par         <= 1'b0;
`endif
      hold_data      <= '0;
      hold_valid     <= 1'b0;
      armed          <= 1'b1;
      rx_done        <= 1'b0;
      data_rx        <= '0;
      out_rx_overrun <= 1'b0;
      out_rx_err     <= 1'b0;
    end else begin
      rx_s1    <= in_uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
`ifdef UART_BYTE_LINK_PARITY_EN
      rx_par   <= rx_par_n;
`endif
      rx_done  <= deliver;
      if (deliver) begin
        data_rx <= hold_data;
        armed   <= 1'b0;
      end else if (rx_trig) begin
        armed <= 1'b1;
      end
      if (rx_good && !hold_valid) begin
        hold_data  <= rx_shift;
        hold_valid <= 1'b1;
      end else if (deliver) begin
        hold_valid <= 1'b0;
      end
      if (rx_good && hold_valid) out_rx_overrun <= 1'b1;
      if (rx_bad) out_rx_err <= 1'b1;
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t       tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic            tx_line_n, tx_done_n;
`ifdef UART_BYTE_LINK_PARITY_EN
  logic            tx_par, tx_par_n;
`endif

  // the line is registered from the next state so it changes together with the state
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = out_uart_tx;
    tx_done_n  = 1'b0;
`ifdef UART_BYTE_LINK_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tx_trig) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_shift_n = data_tx;
          tx_line_n  = 1'b0;
`ifdef UART_BYTE_LINK_PARITY_EN
          tx_par_n   = ^data_tx;
`endif
        end
      end
      TX_START: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
`ifdef UART_BYTE_LINK_PARITY_EN
            tx_state_n = TX_PARITY;
            tx_line_n  = tx_par;
`else
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
`endif
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
`ifdef UART_BYTE_LINK_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
          tx_line_n  = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
          tx_line_n  = 1'b1;
          tx_done_n  = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
`ifdef UART_BYTE_LINK_PARITY_EN
      tx_par      <= 1'b0;
`endif
      out_uart_tx <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_cnt      <= tx_cnt_n;
      tx_bit      <= tx_bit_n;
      tx_shift    <= tx_shift_n;
`ifdef UART_BYTE_LINK_PARITY_EN
      tx_par      <= tx_par_n;
`endif
      out_uart_tx <= tx_line_n;
      tx_done     <= tx_done_n;
    end
  end

endmodule

// File: tb/tb_uart_byte_link.sv
// tb/tb_uart_byte_link.sv - scoreboard bench for uart_byte_link at 8 clocks per bit.
module tb_uart_byte_link;

  localparam int CPB = 8;
`ifdef UART_BYTE_LINK_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_uart_rx = 1'b1;
  logic       out_uart_tx;
  logic       rx_trig = 1'b0;
  logic       rx_done;
  logic [7:0] data_rx;
  logic       tx_trig = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       tx_done;
  logic       out_rx_overrun;
  logic       out_rx_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp[$];
  logic [8:0] tx_exp[$];
  logic       last_par;

  uart_byte_link #(.CLKS_PER_BIT(CPB)) dut (
    .in_clk(clk), .in_rst(in_rst), .in_uart_rx(in_uart_rx), .out_uart_tx(out_uart_tx),
    .rx_trig(rx_trig), .rx_done(rx_done), .data_rx(data_rx),
    .tx_trig(tx_trig), .data_tx(data_tx), .tx_done(tx_done),
    .out_rx_overrun(out_rx_overrun), .out_rx_err(out_rx_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par, input logic stop);
    last_par = par;
    in_uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      in_uart_rx = d[i];
      tick(CPB);
    end
`ifdef UART_BYTE_LINK_PARITY_EN
    in_uart_rx = par;
    tick(CPB);
`endif
    in_uart_rx = stop;
    tick(CPB);
    in_uart_rx = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d, input logic par);
    tx_exp.push_back({par, d});
    data_tx = d;
    tx_trig = 1'b1;
    tick(1);
    tx_trig = 1'b0;
    chk("tx_start_low", {31'd0, out_uart_tx}, 32'd0);
  endtask

  // receive monitor: every rx_done must match the next expected byte
  always @(negedge clk) begin
    if (rx_done) begin
      checks++;
      if (rx_exp.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got data_rx 0x%0h want no rx_done", data_rx);
      end else begin
        logic [7:0] e;
        e = rx_exp.pop_front();
        if (data_rx !== e) begin
          errors++;
          $display("FAIL rx_data got 0x%0h want 0x%0h", data_rx, e);
        end
      end
    end
  end

  // transmit monitor: samples each bit at mid-bit and times tx_done from the start edge
  logic [10:0] tx_got, tx_want;
  logic [8:0]  tx_e;
  int          tx_n;
  logic        tx_early;
  initial begin
    forever begin
      @(negedge clk);
      if (!in_rst && out_uart_tx == 1'b0) begin
        tx_got = '0;
        tx_early = 1'b0;
        tx_n = 0;
        while (tx_n < NB * CPB) begin
          if (tx_n % CPB == CPB / 2) tx_got[tx_n / CPB] = out_uart_tx;
          if (tx_done) tx_early = 1'b1;
          @(negedge clk);
          tx_n++;
        end
        checks++;
        if (!tx_done || tx_early) begin
          errors++;
          $display("FAIL tx_done_timing got done=%0b early=%0b want done=1 early=0", tx_done, tx_early);
        end
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got frame 0x%0h want no frame", tx_got);
        end else begin
          tx_e = tx_exp.pop_front();
          tx_want = '0;
          tx_want[8:1] = tx_e[7:0];
`ifdef UART_BYTE_LINK_PARITY_EN
          tx_want[9] = tx_e[8];
          tx_want[10] = 1'b1;
`else
          tx_want[9] = 1'b1;
`endif
          if (tx_got !== tx_want) begin
            errors++;
            $display("FAIL tx_frame got 0x%0h want 0x%0h", tx_got, tx_want);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_tx_line", {31'd0, out_uart_tx}, 32'd1);
    chk("rst_rx_done", {31'd0, rx_done}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rst_data_rx", {24'd0, data_rx}, 32'h00);
    chk("rst_overrun", {31'd0, out_rx_overrun}, 32'd0);
    chk("rst_err", {31'd0, out_rx_err}, 32'd0);
    in_rst = 1'b0;
    tick(4);

    // armed out of reset: 0x3C delivered without rx_trig
    rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b0, 1'b1);
    tick(10);
    chk("rx_3c_held", {24'd0, data_rx}, 32'h3C);

    // 0xA5 frame, an ignored trigger mid-frame, then back-to-back 0x5A
    send_tx(8'hA5, 1'b0);
    tick(20);
    data_tx = 8'hFF;
    tx_trig = 1'b1;
    tick(1);
    tx_trig = 1'b0;
    for (int i = 0; i < 200 && !tx_done; i++) tick(1);
    chk("tx_done_wait", {31'd0, tx_done}, 32'd1);
    send_tx(8'h5A, 1'b0);
    tick(NB * CPB + 20);

    // disarmed: 0x11 held, 0x22 overruns
    send_rx(8'h11, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b1);
    tick(10);
    chk("overrun_set", {31'd0, out_rx_overrun}, 32'd1);
    rx_exp.push_back(8'h11);
    rx_trig = 1'b1;
    tick(1);
    rx_trig = 1'b0;
    chk("trig_rx_done", {31'd0, rx_done}, 32'd1);
    tick(2);
    rx_trig = 1'b1;
    tick(1);
    rx_trig = 1'b0;
    chk("trig2_no_done", {31'd0, rx_done}, 32'd0);
    tick(10);

    // framing error, then a short glitch on idle line
    send_rx(8'h55, 1'b0, 1'b0);
    tick(10);
    chk("frame_err", {31'd0, out_rx_err}, 32'd1);
    chk("frame_data_kept", {24'd0, data_rx}, 32'h11);
    in_uart_rx = 1'b0;
    tick(3);
    in_uart_rx = 1'b1;
    tick(30);
    chk("glitch_data_kept", {24'd0, data_rx}, 32'h11);

    // full duplex: receive 0x81 while sending 0x7E
    rx_exp.push_back(8'h81);
    fork
      send_rx(8'h81, 1'b0, 1'b1);
      send_tx(8'h7E, 1'b0);
    join
    tick(NB * CPB + 20);
    chk("duplex_data", {24'd0, data_rx}, 32'h81);

`ifdef UART_BYTE_LINK_PARITY_EN
    in_rst = 1'b1;
    tick(2);
    in_rst = 1'b0;
    tick(2);
    chk("par_rst_err", {31'd0, out_rx_err}, 32'd0);
    chk("par_rst_overrun", {31'd0, out_rx_overrun}, 32'd0);
    send_tx(8'h03, 1'b0);
    tick(NB * CPB + 20);
    send_rx(8'h07, 1'b0, 1'b1);
    tick(10);
    chk("par_bad_err", {31'd0, out_rx_err}, 32'd1);
    rx_exp.push_back(8'h07);
    send_rx(8'h07, 1'b1, 1'b1);
    tick(10);
    chk("par_good_data", {24'd0, data_rx}, 32'h07);
`endif

    tick(20);
    chk("rx_queue_empty", rx_exp.size(), 32'd0);
    chk("tx_queue_empty", tx_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
